// File: rtl/seg7_scan.sv
// seg7_scan: four-digit multiplexed 7-segment driver, double-buffered.
// Ports: clk, rst_n (async, active-low); data/dp/blank/lzs captured by load
//        into a pending set; seg/seg_P/AN active-low registered drive;
//        frame_start pulses on the first ON cycle of digit 0.
module seg7_scan #(
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data,
    input  logic [3:0]  dp,
    input  logic [3:0]  blank,
    input  logic        lzs,
    input  logic        load,
    output logic [6:0]  seg,
    output logic        seg_P,
    output logic [3:0]  AN,
    output logic        frame_start
);

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        lzs;
    } disp_t;

    localparam int MAXC = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);
    localparam logic [CW-1:0] BLK_M1 = CW'(BLANK_CYC - 1);

    localparam logic [0:0] S_BLANK = 1'b0;
    localparam logic [0:0] S_ON    = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    disp_t         pend;
    disp_t         shad;

    disp_t       src;
    logic [3:0]  nib;
    logic [15:0] hi;
    logic        sup;
    logic        dark;
    logic [6:0]  nseg;
    logic        np;

    function automatic logic [6:0] hexdec(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'h0: r = 7'h40;
            4'h1: r = 7'h79;
            4'h2: r = 7'h24;
            4'h3: r = 7'h30;
            4'h4: r = 7'h19;
            4'h5: r = 7'h12;
            4'h6: r = 7'h02;
            4'h7: r = 7'h78;
            4'h8: r = 7'h00;
            4'h9: r = 7'h10;
            4'hA: r = 7'h08;
            4'hB: r = 7'h03;
            4'hC: r = 7'h46;
            4'hD: r = 7'h21;
            4'hE: r = 7'h06;
            default: r = 7'h0E;
        endcase
        return r;
    endfunction

    // Digit 0 is shown from the value being copied into shadow on the
    // same edge, so look through to pending when idx is 0.
    always_comb begin
        src  = (idx == 2'd0) ? pend : shad;
        nib  = src.data[{idx, 2'b00} +: 4];
        // nibble idx and everything above it, zero when suppressible
        hi   = src.data >> {idx, 2'b00};
        dark = src.blank[idx];
        sup  = src.lzs && (idx != 2'd0) && (hi == 16'h0000);
        nseg = 7'h7F;
        np   = 1'b1;
        unique case (1'b1)
            dark: begin
                nseg = 7'h7F;
                np   = 1'b1;
            end
            !dark && sup: begin
                nseg = 7'h7F;
                np   = ~src.dp[idx];
            end
            !dark && !sup: begin
                nseg = hexdec(nib);
                np   = ~src.dp[idx];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_BLANK;
            cnt         <= '0;
            idx         <= 2'd0;
            pend        <= '0;
            shad        <= '0;
            AN          <= 4'b1111;
            seg         <= 7'h7F;
            seg_P       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (load) begin
                pend <= {data, dp, blank, lzs};
            end
            if (state == S_BLANK) begin
                if (cnt == BLK_M1) begin
                    state       <= S_ON;
                    cnt         <= '0;
                    AN          <= ~(4'b0001 << idx);
                    seg         <= nseg;
                    seg_P       <= np;
                    frame_start <= (idx == 2'd0);
                    if (idx == 2'd0) begin
                        shad <= pend;
                    end
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                if (cnt == DIV_M1) begin
                    state <= S_BLANK;
                    cnt   <= '0;
                    idx   <= idx + 2'd1;
                    AN    <= 4'b1111;
                    seg   <= 7'h7F;
                    seg_P <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule
